// File: rtl/async_fifo_pkg.sv
// Shared defaults and Gray-code helpers for the Gray-pointer FIFO.
// Helpers work on 32-bit words; callers cast to their pointer width.
package async_fifo_pkg;

    localparam int DEPTH_DEF     = 16;
    localparam int WIDTH_DEF     = 8;
    localparam int PTR_WIDTH_DEF = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_sync2.sv
// Two-flop synchronizer for a Gray-coded pointer, with synchronous active-low reset.
module async_fifo_sync2 #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/async_fifo.sv
// Gray-pointer FIFO on a single clock; pointers still cross through 2-flop
// synchronizers so the datapath is unchanged if the two sides are later split.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int PTR_WIDTH = PTR_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    output logic             wr_error_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             rd_error_o
);

    localparam int PW = PTR_WIDTH + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr, wr_gray, wr_ptr_next;
    logic [PW-1:0] rd_ptr, rd_gray, rd_ptr_next;
    logic [PW-1:0] wq2_wr_gray, rq2_rd_gray;
    logic          accept_wr, accept_rd;

    assign accept_wr   = wr_en_i & ~full_o;
    assign accept_rd   = rd_en_i & ~empty_o;
    assign wr_ptr_next = wr_ptr + PW'(1);
    assign rd_ptr_next = rd_ptr + PW'(1);

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign empty_o = (rd_gray == wq2_wr_gray);
    assign full_o  = (wr_gray == {~rq2_rd_gray[PW-1:PW-2], rq2_rd_gray[PW-3:0]});

    // Storage is not reset; writes are held off while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (rst_i && accept_wr) begin
            mem[wr_ptr[PTR_WIDTH-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr     <= '0;
            wr_gray    <= '0;
            wr_error_o <= 1'b0;
        end else begin
            wr_error_o <= wr_en_i & full_o;
            if (accept_wr) begin
                wr_ptr  <= wr_ptr_next;
                wr_gray <= PW'(bin2gray(32'(wr_ptr_next)));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_ptr     <= '0;
            rd_gray    <= '0;
            rdata_o    <= '0;
            rd_error_o <= 1'b0;
        end else begin
            rd_error_o <= rd_en_i & empty_o;
            if (accept_rd) begin
                rdata_o <= mem[rd_ptr[PTR_WIDTH-1:0]];
                rd_ptr  <= rd_ptr_next;
                rd_gray <= PW'(bin2gray(32'(rd_ptr_next)));
            end
        end
    end

    async_fifo_sync2 #(.W(PW)) u_sync_wr2rd (
        .clk   (clk_i),
        .rst_b (rst_i),
        .d     (wr_gray),
        .q     (wq2_wr_gray)
    );

    async_fifo_sync2 #(.W(PW)) u_sync_rd2wr (
        .clk   (clk_i),
        .rst_b (rst_i),
        .d     (rd_gray),
        .q     (rq2_rd_gray)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: count-based flag model with a 2-cycle
// pointer delay, a data scoreboard queue, a vector table and directed sequences.
module tb_async_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wdata;
    logic       full;
    logic       wr_error;
    logic       rd_en;
    logic [7:0] rdata;
    logic       empty;
    logic       rd_error;

    async_fifo dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wdata_i    (wdata),
        .full_o     (full),
        .wr_error_o (wr_error),
        .rd_en_i    (rd_en),
        .rdata_o    (rdata),
        .empty_o    (empty),
        .rd_error_o (rd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] sb_q[$];
    int  m_wr, m_rd, m_wr_d1, m_wr_d2, m_rd_d1, m_rd_d2;
    bit  m_full, m_empty, m_wr_err, m_rd_err;
    logic [7:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_wr = 0; m_rd = 0;
        m_wr_d1 = 0; m_wr_d2 = 0; m_rd_d1 = 0; m_rd_d2 = 0;
        m_wr_err = 0; m_rd_err = 0;
        m_rdata = 8'h00;
        m_full = 0; m_empty = 1;
    endtask

    // One clock: drive inputs, advance DUT and model, compare all outputs.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit rst_v = 1'b1);
        bit acc_w, acc_r;
        wr_en = w; wdata = d; rd_en = r; rst = rst_v;
        @(posedge clk);
        if (!rst_v) begin
            model_reset();
        end else begin
            acc_w    = w && !m_full;
            acc_r    = r && !m_empty;
            m_wr_err = w && m_full;
            m_rd_err = r && m_empty;
            m_wr_d2 = m_wr_d1; m_wr_d1 = m_wr;
            m_rd_d2 = m_rd_d1; m_rd_d1 = m_rd;
            if (acc_w) begin
                sb_q.push_back(d);
                m_wr++;
            end
            if (acc_r) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL scoreboard_underflow: got read with no stored word at %0t", $time);
                end else begin
                    m_rdata = sb_q.pop_front();
                end
                m_rd++;
            end
            m_full  = (m_wr - m_rd_d2) == 16;
            m_empty = (m_rd == m_wr_d2);
        end
        #1;
        chk("full",     32'(full),     32'(m_full));
        chk("empty",    32'(empty),    32'(m_empty));
        chk("wr_error", 32'(wr_error), 32'(m_wr_err));
        chk("rd_error", 32'(rd_error), 32'(m_rd_err));
        chk("rdata",    32'(rdata),    32'(m_rdata));
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && sb_q.size() > 0; k++) step(1'b0, 8'h00, 1'b1);
        chk("drain_done", 32'(sb_q.size()), 32'd0);
    endtask

    typedef struct {
        bit         w;
        logic [7:0] d;
        bit         r;
        bit         e_empty;
        bit         e_full;
        logic [7:0] e_rdata;
        bit         e_wr_err;
        bit         e_rd_err;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] first16[16];

    initial begin
        vecs[0] = '{0, 8'h00, 1, 1, 0, 8'h00, 0, 1};
        vecs[1] = '{1, 8'hA1, 0, 1, 0, 8'h00, 0, 0};
        vecs[2] = '{1, 8'hB2, 1, 1, 0, 8'h00, 0, 1};
        vecs[3] = '{0, 8'h00, 0, 0, 0, 8'h00, 0, 0};
        vecs[4] = '{0, 8'h00, 1, 0, 0, 8'hA1, 0, 0};
        vecs[5] = '{0, 8'h00, 1, 1, 0, 8'hB2, 0, 0};
        vecs[6] = '{0, 8'h00, 1, 1, 0, 8'hB2, 0, 1};
        vecs[7] = '{0, 8'h00, 0, 1, 0, 8'hB2, 0, 0};

        wr_en = 0; wdata = 0; rd_en = 0; rst = 0;
        model_reset();

        // Reset
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_errs",  32'({wr_error, rd_error}), 32'd0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].w, vecs[i].d, vecs[i].r);
            chk($sformatf("vec%0d_empty", i), 32'(empty),    32'(vecs[i].e_empty));
            chk($sformatf("vec%0d_full", i),  32'(full),     32'(vecs[i].e_full));
            chk($sformatf("vec%0d_rdata", i), 32'(rdata),    32'(vecs[i].e_rdata));
            chk($sformatf("vec%0d_wrerr", i), 32'(wr_error), 32'(vecs[i].e_wr_err));
            chk($sformatf("vec%0d_rderr", i), 32'(rd_error), 32'(vecs[i].e_rd_err));
        end

        // test_full and test_full_error
        step(0, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) begin
            first16[i] = 8'($urandom);
            step(1, first16[i], 0);
            chk("full_before_16th", 32'(full), (i == 15) ? 32'd1 : 32'd0);
            chk("no_wr_error", 32'(wr_error), 32'd0);
        end
        step(1, 8'h5A, 0);
        chk("wr_error_17th", 32'(wr_error), 32'd1);
        step(0, 8'h00, 0);
        chk("wr_error_cleared", 32'(wr_error), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1);
            chk("full_read_order", 32'(rdata), 32'(first16[i]));
        end
        chk("empty_after_16", 32'(empty), 32'd1);

        // test_empty
        for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 8'h00, 1);
            chk("no_rd_error", 32'(rd_error), 32'd0);
        end
        chk("empty_after_8", 32'(empty), 32'd1);

        // test_empty_error
        for (int i = 0; i < 16; i++) begin
            first16[i] = 8'($urandom);
            step(1, first16[i], 0);
        end
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        chk("rd_error_17th", 32'(rd_error), 32'd1);
        chk("rdata_holds_16th", 32'(rdata), 32'(first16[15]));
        step(0, 8'h00, 0);
        chk("rd_error_cleared", 32'(rd_error), 32'd0);

        // Wrap with overlapping write/read traffic
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 16; i++) step(i < 12, 8'($urandom), i >= 3);
            drain();
        end

        // Reset mid-stream discards stored data
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0);
        step(0, 8'h00, 0, 0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        chk("midrst_no_data", 32'(rd_error), 32'd1);
        chk("midrst_rdata_hold", 32'(rdata), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
